// File: rtl/freqdiv_multi.sv
// rtl/freqdiv_multi.sv - NCH-channel programmable clock divider with glitch-free reloads
//
// Each channel divides clk_in by 2*active, producing a 50% duty square wave
// on clk_out[i] and a one-cycle strobe on tick[i] whenever clk_out[i] toggles.
// Divide values are staged in a shadow register while running and applied only
// at terminal count, so a half-period is never cut short or stretched.
//
// Optional feature macro: PHASE_SYNC_EN (adds the sync input that restarts all
// running channels from phase zero in the same cycle).
//
// Ports:
//   clk_in   in   1       board clock, rising edge
//   rst      in   1       asynchronous active-high reset
//   en       in   NCH     per-channel run enable
//   div_val  in   NCH*CW  divide values, channel i at [i*CW +: CW]
//   load     in   NCH     per-channel capture strobe for div_val
//   sync     in   1       (PHASE_SYNC_EN only) restart all running channels
//   clk_out  out  NCH     divided clocks
//   tick     out  NCH     toggle strobes
//   pend     out  NCH     shadow captured but not yet applied
module freqdiv_multi #(
    parameter int NCH         = 2,
    parameter int CW          = 16,
    parameter int DEFAULT_DIV = 100
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [NCH-1:0]    en,
    input  logic [NCH*CW-1:0] div_val,
    input  logic [NCH-1:0]    load,
`ifdef PHASE_SYNC_EN
    input  logic              sync,
`endif
    output logic [NCH-1:0]    clk_out,
    output logic [NCH-1:0]    tick,
    output logic [NCH-1:0]    pend
);

    localparam logic [CW-1:0] DEF_DIV = CW'(DEFAULT_DIV);
    localparam logic [CW-1:0] ONE     = CW'(1);

    typedef enum logic {
        OFF = 1'b0,
        RUN = 1'b1
    } mode_t;

    logic [CW-1:0] cnt_q    [NCH];
    logic [CW-1:0] active_q [NCH];
    logic [CW-1:0] shadow_q [NCH];

    logic [CW-1:0] cnt_d    [NCH];
    logic [CW-1:0] active_d [NCH];
    logic [CW-1:0] shadow_d [NCH];
    logic [NCH-1:0] clk_d;
    logic [NCH-1:0] tick_d;
    logic [NCH-1:0] pend_d;
    mode_t          mode [NCH];

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]    <= '0;
                active_q[i] <= DEF_DIV;
                shadow_q[i] <= DEF_DIV;
            end
            clk_out <= '0;
            tick    <= '0;
            pend    <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]    <= cnt_d[i];
                active_q[i] <= active_d[i];
                shadow_q[i] <= shadow_d[i];
            end
            clk_out <= clk_d;
            tick    <= tick_d;
            pend    <= pend_d;
        end
    end

    always_comb begin
        logic [CW-1:0] dv;
        dv     = '0;
        clk_d  = clk_out;
        tick_d = '0;
        pend_d = pend;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i]    = cnt_q[i];
            active_d[i] = active_q[i];
            shadow_d[i] = shadow_q[i];
            mode[i]     = en[i] ? RUN : OFF;
            dv          = div_val[i*CW +: CW];

            case (mode[i])
                OFF: begin
                    cnt_d[i]  = '0;
                    clk_d[i]  = 1'b0;
                    tick_d[i] = 1'b0;
                    pend_d[i] = 1'b0;
                    // Nothing to keep in phase while stopped, so a staged
                    // value is simply committed and new loads go straight in.
                    if (load[i]) begin
                        active_d[i] = dv;
                        shadow_d[i] = dv;
                    end else if (pend[i]) begin
                        active_d[i] = shadow_q[i];
                    end
                end
                default: begin
`ifdef PHASE_SYNC_EN
                    if (sync) begin
                        cnt_d[i]  = '0;
                        clk_d[i]  = 1'b0;
                        tick_d[i] = 1'b0;
                        pend_d[i] = 1'b0;
                        if (load[i]) begin
                            active_d[i] = dv;
                            shadow_d[i] = dv;
                        end else if (pend[i]) begin
                            active_d[i] = shadow_q[i];
                        end
                    end else
`endif
                    if (active_q[i] == '0) begin
                        // Frozen: output holds; a load takes effect at once
                        // since there is no running half-period to protect.
                        cnt_d[i]  = '0;
                        tick_d[i] = 1'b0;
                        pend_d[i] = 1'b0;
                        if (load[i]) begin
                            active_d[i] = dv;
                            shadow_d[i] = dv;
                        end
                    end else if (cnt_q[i] == active_q[i] - ONE) begin
                        cnt_d[i]  = '0;
                        clk_d[i]  = ~clk_out[i];
                        tick_d[i] = 1'b1;
                        pend_d[i] = 1'b0;
                        if (load[i]) begin
                            active_d[i] = dv;
                            shadow_d[i] = dv;
                        end else if (pend[i]) begin
                            active_d[i] = shadow_q[i];
                        end
                    end else begin
                        cnt_d[i]  = cnt_q[i] + ONE;
                        tick_d[i] = 1'b0;
                        if (load[i]) begin
                            shadow_d[i] = dv;
                            pend_d[i]   = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freqdiv_multi.sv
// tb/tb_freqdiv_multi.sv - directed self-checking bench for freqdiv_multi
module tb_freqdiv_multi;

    logic        clk_in;
    logic        rst;
    logic [1:0]  en;
    logic [31:0] div_val;
    logic [1:0]  load;
`ifdef PHASE_SYNC_EN
    logic        sync;
`endif
    logic [1:0]  clk_out;
    logic [1:0]  tick;
    logic [1:0]  pend;

    int n_cmp;
    int n_fail;

    freqdiv_multi #(.NCH(2), .CW(16), .DEFAULT_DIV(100)) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .en      (en),
        .div_val (div_val),
        .load    (load),
`ifdef PHASE_SYNC_EN
        .sync    (sync),
`endif
        .clk_out (clk_out),
        .tick    (tick),
        .pend    (pend)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 2'b00; load = 2'b00; div_val = '0;
        step(2);
        n_cmp++;
        if ({clk_out, tick, pend} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %b required 000000", {clk_out, tick, pend});
        end
        rst = 1'b0;
        en = 2'b11;
        step(120);
        n_cmp++;
        if (clk_out !== 2'b11) begin
            n_fail++;
            $display("FAIL run_before_rst clk_out: got %b required 11", clk_out);
        end
        div_val[15:0] = 16'd100; load = 2'b01;
        step(1);
        load = 2'b00;
        n_cmp++;
        if (pend !== 2'b01) begin
            n_fail++;
            $display("FAIL pend_before_rst: got %b required 01", pend);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({clk_out, tick, pend} !== 6'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %b required 000000", {clk_out, tick, pend});
        end
        step(1);
        rst = 1'b0;
        en = 2'b01;
        step(99);
        n_cmp++;
        if ({clk_out, tick} !== 4'b0000) begin
            n_fail++;
            $display("FAIL ch0_edge99: got clk_out=%b tick=%b required 00 00", clk_out, tick);
        end
        step(1);
        n_cmp++;
        if ({clk_out, tick} !== 4'b0101) begin
            n_fail++;
            $display("FAIL ch0_edge100: got clk_out=%b tick=%b required 01 01", clk_out, tick);
        end
        step(99);
        n_cmp++;
        if ({clk_out, tick} !== 4'b0100) begin
            n_fail++;
            $display("FAIL ch0_edge199: got clk_out=%b tick=%b required 01 00", clk_out, tick);
        end
        step(1);
        n_cmp++;
        if ({clk_out, tick} !== 4'b0001) begin
            n_fail++;
            $display("FAIL ch0_edge200: got clk_out=%b tick=%b required 00 01", clk_out, tick);
        end
    endtask

    task automatic test_div_3_5();
        logic [1:0] exp_tick, exp_clk;
        en = 2'b00;
        step(1);
        div_val = {16'd5, 16'd3}; load = 2'b11;
        step(1);
        load = 2'b00;
        n_cmp++;
        if (pend !== 2'b00) begin
            n_fail++;
            $display("FAIL load_off_pend: got %b required 00", pend);
        end
        en = 2'b11;
        for (int n = 1; n <= 30; n++) begin
            step(1);
            exp_tick = {(n % 5) == 0, (n % 3) == 0};
            exp_clk  = {((n / 5) % 2) == 1, ((n / 3) % 2) == 1};
            n_cmp++;
            if (tick !== exp_tick || clk_out !== exp_clk) begin
                n_fail++;
                $display("FAIL div35 n=%0d: got clk_out=%b tick=%b required %b %b",
                         n, clk_out, tick, exp_clk, exp_tick);
            end
        end
    endtask

    task automatic test_reload();
        logic exp_tick, exp_clk;
        en = 2'b00;
        step(1);
        div_val[15:0] = 16'd10; load = 2'b01;
        step(1);
        load = 2'b00;
        en = 2'b01;
        step(2);
        div_val[15:0] = 16'd4; load = 2'b01;
        step(1);
        load = 2'b00;
        n_cmp++;
        if (pend[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_pend_set: got %b required 1", pend[0]);
        end
        for (int e = 4; e <= 9; e++) begin
            step(1);
            n_cmp++;
            if (pend[0] !== 1'b1 || tick[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL reload_hold e=%0d: got pend=%b tick=%b required 1 0", e, pend[0], tick[0]);
            end
        end
        step(1);
        n_cmp++;
        if ({pend[0], tick[0], clk_out[0]} !== 3'b011) begin
            n_fail++;
            $display("FAIL reload_tc: got pend/tick/clk=%b required 011", {pend[0], tick[0], clk_out[0]});
        end
        for (int e = 11; e <= 18; e++) begin
            step(1);
            exp_tick = ((e - 10) % 4) == 0;
            exp_clk  = 1'b1 ^ (((e - 10) / 4) % 2 == 1);
            n_cmp++;
            if (tick[0] !== exp_tick || clk_out[0] !== exp_clk) begin
                n_fail++;
                $display("FAIL reload_new e=%0d: got clk=%b tick=%b required %b %b",
                         e, clk_out[0], tick[0], exp_clk, exp_tick);
            end
        end
    endtask

    task automatic test_load_on_tc();
        logic c;
        step(3);
        div_val[15:0] = 16'd2; load = 2'b01;
        step(1);
        load = 2'b00;
        n_cmp++;
        if ({pend[0], tick[0], clk_out[0]} !== 3'b010) begin
            n_fail++;
            $display("FAIL load_at_tc: got pend/tick/clk=%b required 010", {pend[0], tick[0], clk_out[0]});
        end
        step(1);
        n_cmp++;
        if ({pend[0], tick[0]} !== 2'b00) begin
            n_fail++;
            $display("FAIL load_at_tc_next: got pend/tick=%b required 00", {pend[0], tick[0]});
        end
        step(1);
        n_cmp++;
        if ({tick[0], clk_out[0]} !== 2'b11) begin
            n_fail++;
            $display("FAIL div2_toggle: got tick/clk=%b required 11", {tick[0], clk_out[0]});
        end
        div_val[15:0] = 16'd1; load = 2'b01;
        step(1);
        load = 2'b00;
        n_cmp++;
        if (pend[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL div1_pend: got %b required 1", pend[0]);
        end
        step(1);
        n_cmp++;
        if ({pend[0], tick[0], clk_out[0]} !== 3'b010) begin
            n_fail++;
            $display("FAIL div1_apply: got pend/tick/clk=%b required 010", {pend[0], tick[0], clk_out[0]});
        end
        c = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(1);
            c = ~c;
            n_cmp++;
            if (tick[0] !== 1'b1 || clk_out[0] !== c) begin
                n_fail++;
                $display("FAIL div1_run k=%0d: got clk=%b tick=%b required %b 1", k, clk_out[0], tick[0], c);
            end
        end
        div_val[15:0] = 16'd0; load = 2'b01;
        step(1);
        load = 2'b00;
        c = ~c;
        step(1);
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (tick[0] !== 1'b0 || clk_out[0] !== c) begin
                n_fail++;
                $display("FAIL div0_frozen k=%0d: got clk=%b tick=%b required %b 0", k, clk_out[0], tick[0], c);
            end
            step(1);
        end
        div_val[15:0] = 16'd3; load = 2'b01;
        step(1);
        load = 2'b00;
        n_cmp++;
        if ({pend[0], tick[0]} !== 2'b00) begin
            n_fail++;
            $display("FAIL unfreeze_load: got pend/tick=%b required 00", {pend[0], tick[0]});
        end
        step(2);
        n_cmp++;
        if (tick[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL unfreeze_early: got tick=%b required 0", tick[0]);
        end
        step(1);
        n_cmp++;
        if (tick[0] !== 1'b1 || clk_out[0] !== ~c) begin
            n_fail++;
            $display("FAIL unfreeze_toggle: got tick=%b clk=%b required 1 %b", tick[0], clk_out[0], ~c);
        end
    endtask

    task automatic test_en_drop();
        int guard;
        guard = 0;
        while (clk_out[0] !== 1'b1 && guard < 10) begin
            step(1);
            guard++;
        end
        n_cmp++;
        if (clk_out[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL en_drop_wait: got clk=%b required 1 within 10 cycles", clk_out[0]);
        end
        step(1);
        en = 2'b00;
        step(1);
        n_cmp++;
        if ({clk_out[0], tick[0]} !== 2'b00) begin
            n_fail++;
            $display("FAIL en_drop: got clk/tick=%b required 00", {clk_out[0], tick[0]});
        end
        en = 2'b01;
        step(2);
        n_cmp++;
        if ({clk_out[0], tick[0]} !== 2'b00) begin
            n_fail++;
            $display("FAIL reenable_early: got clk/tick=%b required 00", {clk_out[0], tick[0]});
        end
        step(1);
        n_cmp++;
        if ({clk_out[0], tick[0]} !== 2'b11) begin
            n_fail++;
            $display("FAIL reenable_toggle: got clk/tick=%b required 11", {clk_out[0], tick[0]});
        end
    endtask

`ifdef PHASE_SYNC_EN
    task automatic test_phase_sync();
        logic [1:0] exp_tick, exp_clk;
        en = 2'b00;
        step(1);
        div_val = {16'd8, 16'd4}; load = 2'b11;
        step(1);
        load = 2'b00;
        en = 2'b01;
        step(3);
        en = 2'b11;
        step(2);
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        n_cmp++;
        if ({clk_out, tick} !== 4'b0000) begin
            n_fail++;
            $display("FAIL sync_restart: got clk_out=%b tick=%b required 00 00", clk_out, tick);
        end
        for (int n = 1; n <= 32; n++) begin
            step(1);
            exp_tick = {(n % 8) == 0, (n % 4) == 0};
            exp_clk  = {((n / 8) % 2) == 1, ((n / 4) % 2) == 1};
            n_cmp++;
            if (tick !== exp_tick || clk_out !== exp_clk) begin
                n_fail++;
                $display("FAIL sync_run n=%0d: got clk_out=%b tick=%b required %b %b",
                         n, clk_out, tick, exp_clk, exp_tick);
            end
        end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b1;
        en = 2'b00;
        load = 2'b00;
        div_val = '0;
`ifdef PHASE_SYNC_EN
        sync = 1'b0;
`endif
        test_reset();
        test_div_3_5();
        test_reload();
        test_load_on_tc();
        test_en_drop();
`ifdef PHASE_SYNC_EN
        test_phase_sync();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
